// File: rtl/fence_ui_pkg.sv
// Shared types and constants for the fence game UI: button FSM states, coordinate widths
// and play-button geometry (also consumed by the start-screen overlay).
package fence_ui_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOVER    = 2'd1,
        FIRE     = 2'd2,
        COOLDOWN = 2'd3
    } btn_state_t;

    localparam int unsigned H_W = 11;
    localparam int unsigned V_W = 10;

    localparam int unsigned PLAY_BTN_X = 380;
    localparam int unsigned PLAY_BTN_Y = 500;
    localparam int unsigned PLAY_BTN_W = 200;
    localparam int unsigned PLAY_BTN_H = 100;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/play_button_ctrl_if.sv
// Cursor/frame inputs and overlay outputs of the play-button controller.
// click_in exists only when PLAY_BTN_CLICK_EN is defined.
interface play_button_ctrl_if;
    import fence_ui_pkg::*;

    logic             frame_done_in;
    logic             enable_in;
    logic             cursor_valid_in;
    logic [H_W-1:0]   cursor_x_in;
    logic [V_W-1:0]   cursor_y_in;
`ifdef PLAY_BTN_CLICK_EN
    logic             click_in;
`endif
    logic             hover_out;
    logic [7:0]       dwell_progress_out;
    logic             start_game_out;
    btn_state_t       state_out;

    modport master (
`ifdef PLAY_BTN_CLICK_EN
        output click_in,
`endif
        output frame_done_in,
        output enable_in,
        output cursor_valid_in,
        output cursor_x_in,
        output cursor_y_in,
        input  hover_out,
        input  dwell_progress_out,
        input  start_game_out,
        input  state_out
    );

    modport slave (
`ifdef PLAY_BTN_CLICK_EN
        input  click_in,
`endif
        input  frame_done_in,
        input  enable_in,
        input  cursor_valid_in,
        input  cursor_x_in,
        input  cursor_y_in,
        output hover_out,
        output dwell_progress_out,
        output start_game_out,
        output state_out
    );

endinterface

// File: rtl/rect_hit.sv
// Purely combinational point-in-rectangle test with half-open ranges [X, X+W) x [Y, Y+H).
module rect_hit
    import fence_ui_pkg::*;
#(
    parameter int unsigned X = PLAY_BTN_X,
    parameter int unsigned Y = PLAY_BTN_Y,
    parameter int unsigned W = PLAY_BTN_W,
    parameter int unsigned H = PLAY_BTN_H
) (
    input  logic           valid_i,
    input  logic [H_W-1:0] x_i,
    input  logic [V_W-1:0] y_i,
    output logic           hit_o
);

    logic in_x;
    logic in_y;

    always_comb begin
        in_x  = (32'(x_i) >= X) && (32'(x_i) < X + W);
        in_y  = (32'(y_i) >= Y) && (32'(y_i) < Y + H);
        hit_o = valid_i && in_x && in_y;
    end

endmodule

// File: rtl/play_button_ctrl.sv
// Start-screen play button: per-frame hit test, dwell timer, one-cycle start_game pulse.
// Define PLAY_BTN_CLICK_EN to add an immediate click-to-fire path while hovering.
module play_button_ctrl
    import fence_ui_pkg::*;
#(
    parameter int unsigned BTN_X           = PLAY_BTN_X,
    parameter int unsigned BTN_Y           = PLAY_BTN_Y,
    parameter int unsigned BTN_W           = PLAY_BTN_W,
    parameter int unsigned BTN_H           = PLAY_BTN_H,
    parameter int unsigned DWELL_FRAMES    = 60,
    parameter int unsigned LOST_FRAMES     = 4,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input logic               clk_in,
    input logic               rst_in,
    play_button_ctrl_if.slave bus
);

    localparam int unsigned PROG_SCALE = (255 << 16) / DWELL_FRAMES;
    localparam logic [7:0]  DWELL_CNT  = 8'(DWELL_FRAMES);
    // Saturating 8-bit counters can never exceed 255, so clamp the thresholds.
    localparam logic [7:0]  LOST_CNT   = (LOST_FRAMES > 255) ? 8'd255 : 8'(LOST_FRAMES);
    localparam logic [7:0]  COOL_CNT   = (COOLDOWN_FRAMES > 255) ? 8'd255 : 8'(COOLDOWN_FRAMES);

    function automatic logic [7:0] progress(input logic [7:0] dwell);
        logic [31:0] scaled;
        scaled = (32'(dwell) * PROG_SCALE) >> 16;
        return (scaled > 32'd255) ? 8'd255 : scaled[7:0];
    endfunction

    btn_state_t state_q, state_d;
    logic [7:0] dwell_q, dwell_d;
    logic [7:0] miss_q, miss_d;
    logic [7:0] cool_q, cool_d;
    logic [7:0] dwell_inc, miss_inc, cool_inc;
    logic       hover_q, start_q;
    logic [7:0] prog_q, prog_d;
    logic       hit;
    logic       click_fire;

    rect_hit #(
        .X(BTN_X),
        .Y(BTN_Y),
        .W(BTN_W),
        .H(BTN_H)
    ) u_hit (
        .valid_i(bus.cursor_valid_in),
        .x_i    (bus.cursor_x_in),
        .y_i    (bus.cursor_y_in),
        .hit_o  (hit)
    );

`ifdef PLAY_BTN_CLICK_EN
    logic click_q;
    logic last_hit_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            click_q    <= 1'b0;
            last_hit_q <= 1'b0;
        end else begin
            click_q <= bus.click_in;
            if (bus.frame_done_in) last_hit_q <= hit;
        end
    end

    assign click_fire = bus.click_in && !click_q && last_hit_q;
`else
    assign click_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        miss_d    = miss_q;
        cool_d    = cool_q;
        dwell_inc = sat_inc8(dwell_q);
        miss_inc  = sat_inc8(miss_q);
        cool_inc  = sat_inc8(cool_q);

        if (!bus.enable_in) begin
            state_d = IDLE;
            dwell_d = 8'd0;
            miss_d  = 8'd0;
            cool_d  = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.frame_done_in && hit) begin
                        dwell_d = 8'd1;
                        miss_d  = 8'd0;
                        state_d = (8'd1 >= DWELL_CNT) ? FIRE : HOVER;
                    end
                end
                HOVER: begin
                    if (click_fire) begin
                        state_d = FIRE;
                    end else if (bus.frame_done_in) begin
                        if (hit) begin
                            dwell_d = dwell_inc;
                            miss_d  = 8'd0;
                            if (dwell_inc >= DWELL_CNT) state_d = FIRE;
                        end else begin
                            miss_d = miss_inc;
                            if (miss_inc >= LOST_CNT) begin
                                state_d = IDLE;
                                dwell_d = 8'd0;
                                miss_d  = 8'd0;
                            end
                        end
                    end
                end
                FIRE: begin
                    state_d = COOLDOWN;
                    dwell_d = 8'd0;
                    miss_d  = 8'd0;
                    cool_d  = 8'd0;
                end
                COOLDOWN: begin
                    if (bus.frame_done_in) begin
                        cool_d = cool_inc;
                        if (cool_inc >= COOL_CNT) begin
                            state_d = IDLE;
                            cool_d  = 8'd0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        prog_d = 8'd0;
        if (state_d == HOVER)     prog_d = progress(dwell_d);
        else if (state_d == FIRE) prog_d = 8'd255;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            dwell_q <= 8'd0;
            miss_q  <= 8'd0;
            cool_q  <= 8'd0;
            hover_q <= 1'b0;
            start_q <= 1'b0;
            prog_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            miss_q  <= miss_d;
            cool_q  <= cool_d;
            hover_q <= (state_d == HOVER);
            start_q <= (state_d == FIRE);
            prog_q  <= prog_d;
        end
    end

    assign bus.hover_out          = hover_q;
    assign bus.dwell_progress_out = prog_q;
    // Dropping enable during the FIRE cycle itself must still kill the pulse.
    assign bus.start_game_out     = start_q && bus.enable_in;
    assign bus.state_out          = state_q;

endmodule
